node_report_tx: RTL and testbench



---
 rtl/node_link_pkg.sv | 22 ++
 rtl/node_report_tx_if.sv | 22 ++
 rtl/uart_tx_byte.sv | 61 ++++++
 rtl/node_report_tx.sv | 121 ++++++++++++
 tb/tb_node_report_tx.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/node_link_pkg.sv
// Shared definitions for the robot-to-base node report link.
// Imported by both the on-robot transmitter and the base-station receiver.
package node_link_pkg;

    localparam logic [7:0] SOF_BYTE    = 8'h7E;
    localparam int         FRAME_BYTES = 5;
    localparam int         COUNT_W     = 7;
    localparam int         MOIST_W     = 13;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } tx_state_e;

    function automatic logic [7:0] frame_checksum(input logic [7:0] b1,
                                                  input logic [7:0] b2,
                                                  input logic [7:0] b3);
        return b1 ^ b2 ^ b3;
    endfunction

endpackage

// File: rtl/node_report_tx_if.sv
// Node-report port bundle: detection inputs from navigation and the XBee-side outputs.
interface node_report_tx_if;
    import node_link_pkg::*;

    logic               node_event;
    logic               node_side;
    logic [MOIST_W-1:0] moisture;
    logic               tx;
    logic               busy;
    logic               dropped;

    modport master (
        output node_event, node_side, moisture,
        input  tx, busy, dropped
    );

    modport slave (
        input  node_event, node_side, moisture,
        output tx, busy, dropped
    );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer with a CLK_DIV-cycle bit period and a registered line output.
// Back-to-back starts produce gapless frames.
module uart_tx_byte #(
    parameter int CLK_DIV = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam logic [15:0] LAST_CNT = 16'(CLK_DIV - 1);
    localparam logic [15:0] DONE_CNT = 16'(CLK_DIV - 2);

    logic        active;
    logic [3:0]  bit_idx;
    logic [15:0] cnt;
    logic [7:0]  data_q;
    logic        bit_end;
    logic        ready;

    assign bit_end = (cnt == LAST_CNT);

    // NOTE: done fires one cycle before the stop bit ends, and the last stop-bit
    // cycle counts as idle, so a caller's one-cycle SEND step lands on the boundary.
    assign done  = active && (bit_idx == 4'd9) && (cnt == DONE_CNT);
    assign ready = !active || ((bit_idx == 4'd9) && bit_end);

    // NOTE: sequential state uses non-blocking assignments only; the async reset
    // drives the line high the moment reset rises.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active  <= 1'b0;
            bit_idx <= '0;
            cnt     <= '0;
            data_q  <= '0;
            tx      <= 1'b1;
        end else if (start && ready) begin
            active  <= 1'b1;
            bit_idx <= '0;
            cnt     <= '0;
            data_q  <= data;
            tx      <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active <= 1'b0;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    tx      <= (bit_idx == 4'd8) ? 1'b1 : data_q[bit_idx[2:0]];
                end
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/node_report_tx.sv
// Latches a node report and sends it to the XBee as a 5-byte 8N1 packet:
// 7E, {side,count}, moisture hi, moisture lo, XOR checksum.
module node_report_tx
    import node_link_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  logic             clock,
    input  logic             reset,
    node_report_tx_if.slave  link
);

    tx_state_e          state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [COUNT_W-1:0] count_q;
    logic [7:0]         b1_q, b2_q, b3_q, b4_q;
    logic [7:0]         b1_d, b2_d, b3_d;
    logic               busy_q, dropped_q;
    logic               accept;
    logic               ser_start, ser_done, ser_tx;
    logic [7:0]         ser_data;

    assign accept = link.node_event && !busy_q;

    assign b1_d = {link.node_side, count_q};
    assign b2_d = {3'b000, link.moisture[MOIST_W-1:8]};
    assign b3_d = link.moisture[7:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ser_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                ser_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (ser_done) begin
                    if (idx_q == 3'(FRAME_BYTES - 1)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = SEND;
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ser_data = SOF_BYTE;
        unique case (idx_q)
            3'd1:    ser_data = b1_q;
            3'd2:    ser_data = b2_q;
            3'd3:    ser_data = b3_q;
            3'd4:    ser_data = b4_q;
            default: ser_data = SOF_BYTE;
        endcase
    end

    // busy spans the FSM plus the final stop bit, which ends one cycle after IDLE is re-entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
            count_q   <= '0;
        end else begin
            busy_q    <= accept || (busy_q && (state_q != IDLE));
            dropped_q <= link.node_event && busy_q;
            if (link.node_event) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // NOTE: the payload registers are left without reset; they are only read after
    // an accept has loaded them.
    always_ff @(posedge clock) begin
        if (accept) begin
            b1_q <= b1_d;
            b2_q <= b2_d;
            b3_q <= b3_d;
            b4_q <= frame_checksum(b1_d, b2_d, b3_d);
        end
    end

    uart_tx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_uart_tx_byte (
        .clock (clock),
        .reset (reset),
        .start (ser_start),
        .data  (ser_data),
        .tx    (ser_tx),
        .done  (ser_done)
    );

    assign link.tx      = ser_tx;
    assign link.busy    = busy_q;
    assign link.dropped = dropped_q;

endmodule

// File: tb/tb_node_report_tx.sv
// Directed bench for node_report_tx: checks the tx waveform cycle by cycle against
// hand-computed packets, plus busy/dropped timing and reset behaviour.
module tb_node_report_tx;
    import node_link_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int PKT_CYC = 50 * CLK_DIV;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    node_report_tx_if link();

    node_report_tx #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clock (clock),
        .reset (reset),
        .link  (link)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Byte i of the packet sits at bits [8i +: 8].
    function automatic logic [39:0] make_packet(input logic side, input logic [6:0] cnt,
                                                input logic [12:0] moist);
        logic [7:0] b1, b2, b3;
        b1 = {side, cnt};
        b2 = {3'b000, moist[12:8]};
        b3 = moist[7:0];
        return {b1 ^ b2 ^ b3, b3, b2, b1, 8'h7E};
    endfunction

    function automatic logic exp_bit(input logic [39:0] pkt, input int k);
        logic [7:0] by;
        int p;
        by = pkt[8*(k/10) +: 8];
        p  = k % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return by[p-1];
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        link.node_event = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge with n = that edge.
    task automatic pulse_event(input logic side, input logic [12:0] moist, output int n);
        link.node_event = 1'b1;
        link.node_side  = side;
        link.moisture   = moist;
        @(negedge clock);
        n = cyc;
        link.node_event = 1'b0;
        link.node_side  = ~side;
        link.moisture   = ~moist;
    endtask

    // Checks tx/busy/dropped on every cycle from N to N+50*CLK_DIV+1; optionally
    // drives a second event at negedge of cycle inject_at (sampled at the next edge).
    task automatic check_packet(input string name, input int n, input logic [39:0] pkt,
                                input int inject_at);
        int   bad_tx, bad_busy, bad_drop;
        logic exp_tx, exp_busy, exp_drop;
        logic got_tx, got_busy, got_drop;
        logic want_tx, want_busy, want_drop;
        bad_tx = -1; bad_busy = -1; bad_drop = -1;
        got_tx = 1'b0; got_busy = 1'b0; got_drop = 1'b0;
        want_tx = 1'b0; want_busy = 1'b0; want_drop = 1'b0;
        for (int c = n; c <= n + PKT_CYC + 1; c++) begin
            if (c > n) @(negedge clock);
            exp_tx   = (c == n || c > n + PKT_CYC) ? 1'b1 : exp_bit(pkt, (c - n - 1) / CLK_DIV);
            exp_busy = (c <= n + PKT_CYC);
            exp_drop = (inject_at >= 0) && (c == inject_at + 1);
            if (link.tx !== exp_tx && bad_tx < 0) begin
                bad_tx = c - n; got_tx = link.tx; want_tx = exp_tx;
            end
            if (link.busy !== exp_busy && bad_busy < 0) begin
                bad_busy = c - n; got_busy = link.busy; want_busy = exp_busy;
            end
            if (link.dropped !== exp_drop && bad_drop < 0) begin
                bad_drop = c - n; got_drop = link.dropped; want_drop = exp_drop;
            end
            if (inject_at >= 0 && c == inject_at) begin
                link.node_event = 1'b1;
                link.node_side  = 1'b0;
                link.moisture   = 13'h1555;
            end
            if (inject_at >= 0 && c == inject_at + 1) link.node_event = 1'b0;
        end
        checks++;
        if (bad_tx >= 0) begin
            errors++;
            $display("FAIL %s tx at cycle N+%0d: got %b expected %b (packet %h)",
                     name, bad_tx, got_tx, want_tx, pkt);
        end
        checks++;
        if (bad_busy >= 0) begin
            errors++;
            $display("FAIL %s busy at cycle N+%0d: got %b expected %b", name, bad_busy, got_busy, want_busy);
        end
        checks++;
        if (bad_drop >= 0) begin
            errors++;
            $display("FAIL %s dropped at cycle N+%0d: got %b expected %b", name, bad_drop, got_drop, want_drop);
        end
    endtask

    task automatic test_reset();
        int bad;
        repeat (3) @(negedge clock);
        checks++;
        if ({link.tx, link.busy, link.dropped} !== 3'b100) begin
            errors++;
            $display("FAIL reset_hold {tx,busy,dropped}: got %b expected 100",
                     {link.tx, link.busy, link.dropped});
        end
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if ({link.tx, link.busy, link.dropped} !== 3'b100) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_100 {tx,busy,dropped}: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_single();
        int n;
        pulse_event(1'b1, 13'h1A5C, n);
        check_packet("single", n, 40'hC6_5C_1A_80_7E, -1);
    endtask

    task automatic test_drop();
        int n;
        do_reset();
        pulse_event(1'b1, 13'h1A5C, n);
        check_packet("drop_inflight", n, 40'hC6_5C_1A_80_7E, n + 1 + 20 * CLK_DIV);
        pulse_event(1'b0, 13'h0000, n);
        check_packet("after_drop", n, 40'h02_00_00_02_7E, -1);
    endtask

    // Count is 3 on entry: the packet reports 3, the edge event takes 4, the next reports 5.
    task automatic test_busy_edge();
        int n;
        pulse_event(1'b0, 13'h0F0F, n);
        check_packet("busy_edge", n, make_packet(1'b0, 7'd3, 13'h0F0F), n + PKT_CYC);
        pulse_event(1'b1, 13'h10F0, n);
        check_packet("edge_next", n, make_packet(1'b1, 7'd5, 13'h10F0), -1);
    endtask

    task automatic test_reset_mid();
        int n;
        pulse_event(1'b0, 13'h0000, n);
        while (cyc < n + 1 + 22 * CLK_DIV + 1) @(negedge clock);
        checks++;
        if (link.tx !== 1'b0) begin
            errors++;
            $display("FAIL mid_b2_tx_low: got %b expected 0", link.tx);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (link.tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_async_tx: got %b expected 1", link.tx);
        end
        checks++;
        if (link.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_busy: got %b expected 0", link.busy);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({link.tx, link.busy, link.dropped} !== 3'b100) begin
            errors++;
            $display("FAIL post_reset_idle {tx,busy,dropped}: got %b expected 100",
                     {link.tx, link.busy, link.dropped});
        end
        pulse_event(1'b1, 13'h1FFF, n);
        check_packet("after_reset", n, 40'h60_FF_1F_80_7E, -1);
    endtask

    task automatic test_wrap();
        int n;
        logic [12:0] moist;
        logic side;
        do_reset();
        for (int i = 0; i < 130; i++) begin
            side  = i[0];
            moist = 13'((i * 37 + 5) % 8192);
            pulse_event(side, moist, n);
            check_packet($sformatf("wrap_%0d", i), n, make_packet(side, 7'(i % 128), moist), -1);
        end
    endtask

    initial begin
        link.node_event = 1'b0;
        link.node_side  = 1'b0;
        link.moisture   = '0;
        test_reset();
        test_single();
        test_drop();
        test_busy_edge();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
